seg_counter_display: RTL and testbench

- Parametrised successor to the free-running demo counter: a prescaled up/down counter shown as two hex digits on the 7-segment pair and in binary on the LEDs.
- Four push switches control run/pause, direction, single-step and clear, each debounced in hardware.
- Top-level board block; it drives the 7-segment and LED pins directly.

---
 rtl/seg_counter_pkg.sv | 47 ++++
 rtl/seg_counter_display_debounce.sv | 53 +++++
 rtl/seg_counter_display.sv | 155 +++++++++++++++
 tb/tb_seg_counter_display.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg_counter_pkg.sv
// seg_counter_pkg
// Shared constants and helpers for the seg_counter_display board block.
//   - DISPLAY_HEX / DISPLAY_CHASE : values accepted by the DISPLAY_MODE parameter
//   - SW_* : bit positions of the four push switches on i_Switch
//   - count_dir_e : counting direction
//   - hex_to_seg() : 4-bit value to active-low 7-segment pattern (bit0=A .. bit6=G)
package seg_counter_pkg;

  localparam int DISPLAY_HEX   = 0;
  localparam int DISPLAY_CHASE = 1;

  localparam int NUM_SWITCHES = 4;
  localparam int SW_RUN       = 0;
  localparam int SW_DIR       = 1;
  localparam int SW_STEP      = 2;
  localparam int SW_CLEAR     = 3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } count_dir_e;

  // Active-low segment patterns for the hex digits 0-F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_counter_display_debounce.sv
// switch_debounce
// Debounces one push switch. The accepted level only changes after the raw
// input has disagreed with it for DEBOUNCE_CYCLES consecutive clocks, so any
// glitch shorter than that is never seen downstream.
// Ports:
//   i_Clk    : system clock
//   i_Reset  : synchronous active-high reset (level and counter to 0)
//   i_Switch : raw switch level, expected to already be in the i_Clk domain
//   o_Level  : debounced (accepted) level
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Level
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 level_q, level_d;
  logic [CNT_WIDTH-1:0] stable_cnt_q, stable_cnt_d;

  // The counter holds how many consecutive clocks the raw input has differed
  // from the accepted level; the flip happens on the clock where it already
  // holds DEBOUNCE_CYCLES-1, i.e. the DEBOUNCE_CYCLES-th differing sample.
  always_comb begin
    level_d      = level_q;
    stable_cnt_d = '0;
    if (i_Switch != level_q) begin
      if (stable_cnt_q == CNT_LAST) begin
        level_d      = ~level_q;
        stable_cnt_d = '0;
      end else begin
        stable_cnt_d = stable_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      level_q      <= 1'b0;
      stable_cnt_q <= '0;
    end else begin
      level_q      <= level_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign o_Level = level_q;

endmodule

// File: rtl/seg_counter_display.sv
// seg_counter_display
// Prescaled up/down counter shown as two digits on the 7-segment pair and in
// binary on the LEDs. Four debounced push switches give run/pause, direction,
// single-step and clear.
// Ports:
//   i_Clk      : system clock
//   i_Reset    : synchronous active-high reset
//   i_Switch   : raw buttons, active-high; [0]=run/pause [1]=direction
//                [2]=step [3]=clear
//   o_Segment1 : left digit, active-low, bit0=A .. bit6=G
//   o_Segment2 : right digit, active-low, same bit order
//   o_LED      : count[3:0], bits at or above COUNT_WIDTH driven 0
module seg_counter_display
  import seg_counter_pkg::*;
#(
  parameter int DIV_WIDTH       = 22,
  parameter int COUNT_WIDTH     = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DISPLAY_MODE    = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [6:0]              o_Segment1,
  output logic [6:0]              o_Segment2,
  output logic [3:0]              o_LED
);

  localparam bit CHASE_MODE = (DISPLAY_MODE == DISPLAY_CHASE);
  // Display contents for a count of zero, loaded directly on reset.
  localparam logic [6:0] SEG1_RESET = CHASE_MODE ? 7'b1111110 : 7'b1000000;
  localparam logic [6:0] SEG2_RESET = CHASE_MODE ? 7'b1111111 : 7'b1000000;

  logic [DIV_WIDTH-1:0]    prescaler_q, prescaler_d;
  logic                    tick;
  logic [NUM_SWITCHES-1:0] level;
  logic [NUM_SWITCHES-1:0] level_prev_q, level_prev_d;
  logic [NUM_SWITCHES-1:0] press_q, press_d;
  logic                    running_q, running_d;
  count_dir_e              dir_q, dir_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [COUNT_WIDTH-1:0]  count_step;
  logic [7:0]              disp_value;
  logic [2:0]              chase_low;
  logic [6:0]              seg1_q, seg1_d;
  logic [6:0]              seg2_q, seg2_d;
  logic [3:0]              led_q, led_d;

  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_debounce
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Switch(i_Switch[i]),
      .o_Level (level[i])
    );
  end

  // Prescaler runs regardless of pause; tick marks its last state before wrap.
  always_comb begin
    prescaler_d = prescaler_q + DIV_WIDTH'(1);
    tick        = &prescaler_q;
  end

  // Press pulses come from the registered previous level, so each rising
  // accepted level produces exactly one registered single-cycle pulse.
  always_comb begin
    level_prev_d = level;
    press_d      = level & ~level_prev_q;
  end

  // Control and count both act on the registered press pulse. The count uses
  // the current dir_q, so a direction toggle coinciding with a tick only
  // affects later ticks.
  always_comb begin
    running_d = running_q ^ press_q[SW_RUN];
    dir_d     = dir_q;
    if (press_q[SW_DIR]) begin
      dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
    end

    if (dir_q == DIR_UP) begin
      count_step = count_q + COUNT_WIDTH'(1);
    end else begin
      count_step = count_q - COUNT_WIDTH'(1);
    end

    count_d = count_q;
    if (press_q[SW_CLEAR]) begin
      count_d = '0;
    end else if (press_q[SW_STEP] && !running_q) begin
      count_d = count_step;
    end else if (tick && running_q) begin
      count_d = count_step;
    end
  end

  // Display decode from the count zero-extended to 8 bits. In chase mode the
  // value 7..13 lights Segment2 bit (value-7); since value-7 and value+1 agree
  // modulo 8, the low three bits plus one give that position directly.
  always_comb begin
    disp_value = 8'(count_q);
    chase_low  = disp_value[2:0] + 3'd1;
    led_d      = disp_value[3:0];
    seg1_d     = 7'h7F;
    seg2_d     = 7'h7F;
    case (DISPLAY_MODE)
      DISPLAY_CHASE: begin
        if (disp_value < 8'd7) begin
          seg1_d[disp_value[2:0]] = 1'b0;
        end else if (disp_value < 8'd14) begin
          seg2_d[chase_low] = 1'b0;
        end
      end
      DISPLAY_HEX: begin
        seg1_d = hex_to_seg(disp_value[7:4]);
        seg2_d = hex_to_seg(disp_value[3:0]);
      end
      default: begin
        seg1_d = hex_to_seg(disp_value[7:4]);
        seg2_d = hex_to_seg(disp_value[3:0]);
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      prescaler_q  <= '0;
      level_prev_q <= '0;
      press_q      <= '0;
      running_q    <= 1'b1;
      dir_q        <= DIR_UP;
      count_q      <= '0;
      seg1_q       <= SEG1_RESET;
      seg2_q       <= SEG2_RESET;
      led_q        <= '0;
    end else begin
      prescaler_q  <= prescaler_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      running_q    <= running_d;
      dir_q        <= dir_d;
      count_q      <= count_d;
      seg1_q       <= seg1_d;
      seg2_q       <= seg2_d;
      led_q        <= led_d;
    end
  end

  assign o_Segment1 = seg1_q;
  assign o_Segment2 = seg2_q;
  assign o_LED      = led_q;

endmodule

// File: tb/tb_seg_counter_display.sv
// tb_seg_counter_display
// Directed bench for seg_counter_display. One instance runs in hex mode with
// an 8-bit counter and is driven through the switch sequences; a second,
// chase-mode instance with a 4-bit counter free-runs alongside it.
module tb_seg_counter_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] swChase;
  logic [6:0] seg1, seg2, chaseSeg1, chaseSeg2;
  logic [3:0] led, chaseLed;

  int checks   = 0;
  int failures = 0;
  int edgeNum  = 0;

  logic [6:0] hexTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_counter_display #(
    .DIV_WIDTH(4), .COUNT_WIDTH(8), .DEBOUNCE_CYCLES(4), .DISPLAY_MODE(0)
  ) dut (
    .i_Clk(clk), .i_Reset(reset), .i_Switch(sw),
    .o_Segment1(seg1), .o_Segment2(seg2), .o_LED(led)
  );

  seg_counter_display #(
    .DIV_WIDTH(4), .COUNT_WIDTH(4), .DEBOUNCE_CYCLES(4), .DISPLAY_MODE(1)
  ) dutChase (
    .i_Clk(clk), .i_Reset(reset), .i_Switch(swChase),
    .o_Segment1(chaseSeg1), .o_Segment2(chaseSeg2), .o_LED(chaseLed)
  );

  // Clock with rising edges at 5, 15, 25 ...; edgeNum counts rising edges.
  always #5 clk = ~clk;

  always @(posedge clk) edgeNum <= edgeNum + 1;

  // Drive the switches and let the given number of falling edges pass.
  task automatic applyStimulus(input logic [3:0] pattern, input int cycles);
    sw = pattern;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkHex(input string tag, input logic [7:0] value);
    checkOutput({tag, "_seg1"}, {1'b0, seg1}, {1'b0, hexTable[value[7:4]]});
    checkOutput({tag, "_seg2"}, {1'b0, seg2}, {1'b0, hexTable[value[3:0]]});
    checkOutput({tag, "_led"}, {4'h0, led}, {4'h0, value[3:0]});
  endtask

  // Chase pattern as one 14-bit active-low row: positions 0-6 on Segment1,
  // 7-13 on Segment2.
  function automatic logic [13:0] chaseExpect(input int v);
    logic [13:0] row;
    row = '1;
    if (v < 14) row[v] = 1'b0;
    return row;
  endfunction

  task automatic checkChase(input string tag, input int v);
    logic [13:0] row;
    logic [7:0]  vByte;
    row   = chaseExpect(v);
    vByte = 8'(v);
    checkOutput({tag, "_seg1"}, {1'b0, chaseSeg1}, {1'b0, row[6:0]});
    checkOutput({tag, "_seg2"}, {1'b0, chaseSeg2}, {1'b0, row[13:7]});
    checkOutput({tag, "_led"}, {4'h0, chaseLed}, {4'h0, vByte[3:0]});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at edge %0d", edgeNum);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset   = 1'b1;
    sw      = 4'h0;
    swChase = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state, edge 3.
    checkHex("reset", 8'h00);
    checkChase("reset_chase", 0);

    // First tick lands on edge 19; display follows on edge 20.
    applyStimulus(4'h0, 16);
    checkOutput("tick_latency", {1'b0, seg2}, {1'b0, 7'h40});
    applyStimulus(4'h0, 1);
    checkHex("first_tick", 8'h01);

    // Free run through 17 ticks, sampling mid-window (edges 28, 44 ... 284).
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(4'h0, (k == 1) ? 8 : 16);
      checkHex("free_run", 8'(k));
      checkChase("chase", k % 16);
    end

    // Pause, then confirm the count stays put.
    applyStimulus(4'b0001, 6);
    applyStimulus(4'h0, 100);
    checkHex("paused", 8'h11);

    // Three single steps while paused.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 6);
      applyStimulus(4'h0, 6);
    end
    checkHex("stepped", 8'h14);

    // Clear, reverse direction, step down through zero.
    applyStimulus(4'b1000, 6);
    applyStimulus(4'h0, 6);
    checkHex("paused_clear", 8'h00);
    applyStimulus(4'b0010, 6);
    applyStimulus(4'h0, 6);
    applyStimulus(4'b0100, 6);
    applyStimulus(4'h0, 6);
    checkHex("wrap_down", 8'hFF);

    // Short pulse then 2-clock bouncing on clear must be rejected.
    applyStimulus(4'b1000, 3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h0, 2);
      applyStimulus(4'b1000, 2);
    end
    applyStimulus(4'h0, 6);
    checkHex("bounce_ignored", 8'hFF);

    // Clean clear: accepted on edge 495, pulse 496, count 497, display 498.
    applyStimulus(4'b1000, 6);
    applyStimulus(4'h0, 0);
    checkHex("clear_latency", 8'hFF);
    applyStimulus(4'h0, 1);
    checkHex("clear", 8'h00);

    // Resume running (still counting down).
    applyStimulus(4'b0001, 6);
    applyStimulus(4'h0, 6);

    // Align so the clear pulse acts on a tick edge (edgeNum % 16 == 3).
    for (int i = 0; i < 16 && (edgeNum % 16) != 13; i++) @(negedge clk);
    checks++;
    if ((edgeNum % 16) != 13) begin
      failures++;
      $error("[TB] FAIL align observed=%0d expected=13", edgeNum % 16);
    end
    applyStimulus(4'b1000, 6);
    applyStimulus(4'h0, 1);
    checkHex("clear_on_tick", 8'h00);

    // Direction toggle on the next tick edge: that tick still counts down.
    applyStimulus(4'h0, 9);
    applyStimulus(4'b0010, 6);
    applyStimulus(4'h0, 1);
    checkHex("dir_on_tick", 8'hFF);
    applyStimulus(4'h0, 15);
    checkHex("dir_latency", 8'hFF);
    applyStimulus(4'h0, 1);
    checkHex("dir_new_up", 8'h00);

    // Step while running has no effect before the next tick.
    applyStimulus(4'b0100, 6);
    applyStimulus(4'h0, 6);
    checkHex("step_ignored", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
